spike_encoder_array: RTL and testbench

Multi-channel, multi-mode spike encoder. It converts NUM_CH static intensity values into parallel spike trains for the SNN input layer. It generalises the single-channel fixed-period encoder with per-channel intensity, three coding modes (deterministic rate, stochastic Poisson-like, time-to-first-spike) and an atomic intensity load. It sits between the stimulus/sensor interface and the first neuron layer.

---
 rtl/spike_encoder_array.sv | 117 +++++++++++
 tb/tb_spike_encoder_array.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_encoder_array.sv
// Multi-channel spike encoder: converts latched per-channel intensities into
// spike trains using deterministic rate, LFSR-driven Poisson or time-to-first-spike coding.
module spike_encoder_array #(
    parameter int          NUM_CH    = 4,
    parameter int          VAL_W     = 8,
    parameter int          WINDOW    = 256,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic                      load,
    input  logic [NUM_CH*VAL_W-1:0]   intensity,
    output logic [NUM_CH-1:0]         spike_out,
    output logic                      window_start
);

    localparam int                WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [15:0]       SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0]       TAPS   = 16'hB400;
    localparam logic [WCNT_W-1:0] WLAST  = WCNT_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_RATE    = 2'b01,
        MODE_POISSON = 2'b10,
        MODE_TTFS    = 2'b11
    } mode_e;

    logic [NUM_CH-1:0][VAL_W-1:0] int_q, int_d;
    logic [NUM_CH-1:0][VAL_W-1:0] acc_q, acc_d;
    logic [WCNT_W-1:0]            wcnt_q, wcnt_d;
    logic [15:0]                  lfsr_q, lfsr_d;
    mode_e                        mode_q, mode_d;
    logic [NUM_CH-1:0]            spike_q, spike_d;
    logic                         wstart_q, wstart_d;
    logic [VAL_W-1:0]             rnd [NUM_CH];

    // Each channel sees a differently rotated view of the shared LFSR word.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_rnd
        localparam int ROT = (3 * g) % 16;
        assign rnd[g] = VAL_W'((lfsr_q << ROT) | (lfsr_q >> ((16 - ROT) % 16)));
    end

    always_comb begin
        logic [VAL_W:0]   sum;
        logic [VAL_W-1:0] tgt;
        int_d    = int_q;
        acc_d    = acc_q;
        wcnt_d   = wcnt_q;
        lfsr_d   = lfsr_q;
        mode_d   = mode_e'(mode);
        spike_d  = '0;
        wstart_d = 1'b0;
        sum      = '0;
        tgt      = '0;
        if (load) begin
            int_d  = intensity;
            acc_d  = '0;
            wcnt_d = '0;
        end else if (mode_d != mode_q) begin
            acc_d  = '0;
            wcnt_d = '0;
        end else if (enable) begin
            case (mode_q)
                MODE_RATE: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        sum        = {1'b0, acc_q[i]} + {1'b0, int_q[i]};
                        acc_d[i]   = sum[VAL_W-1:0];
                        spike_d[i] = sum[VAL_W];
                    end
                end
                MODE_POISSON: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        spike_d[i] = (rnd[i] < int_q[i]);
                    end
                    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
                end
                MODE_TTFS: begin
                    wstart_d = (wcnt_q == '0);
                    // Fire time is the bitwise complement: higher intensity fires earlier.
                    for (int i = 0; i < NUM_CH; i++) begin
                        tgt        = ~int_q[i];
                        spike_d[i] = (int_q[i] != '0) && (wcnt_q == WCNT_W'(tgt));
                    end
                    wcnt_d = (wcnt_q == WLAST) ? '0 : wcnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_q    <= '0;
            acc_q    <= '0;
            wcnt_q   <= '0;
            lfsr_q   <= SEED;
            mode_q   <= MODE_OFF;
            spike_q  <= '0;
            wstart_q <= 1'b0;
        end else begin
            int_q    <= int_d;
            acc_q    <= acc_d;
            wcnt_q   <= wcnt_d;
            lfsr_q   <= lfsr_d;
            mode_q   <= mode_d;
            spike_q  <= spike_d;
            wstart_q <= wstart_d;
        end
    end

    assign spike_out    = spike_q;
    assign window_start = wstart_q;

endmodule

// File: tb/tb_spike_encoder_array.sv
// Randomized and directed bench for spike_encoder_array against an arithmetic
// reference model of the rate, Poisson and time-to-first-spike coding rules.
module tb_spike_encoder_array;

    localparam int NUM_CH = 4;
    localparam int VAL_W  = 8;
    localparam int WINDOW = 256;
    localparam int LEVELS = 1 << VAL_W;

    logic                    clk;
    logic                    rst_n;
    logic                    enable;
    logic [1:0]              mode;
    logic                    load;
    logic [NUM_CH*VAL_W-1:0] intensity;
    logic [NUM_CH-1:0]       spike_out;
    logic                    window_start;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model state
    int         intM [NUM_CH];
    int         accM [NUM_CH];
    int         wcntM;
    int         lfsrM;
    int         modeM;
    logic [3:0] expSpike;
    logic       expWs;

    // Per-run statistics gathered from the DUT outputs
    int cnt [NUM_CH];
    int firstIdx [NUM_CH];
    int secondIdx [NUM_CH];
    int wsCount;
    int wsFirst;

    spike_encoder_array #(
        .NUM_CH   (NUM_CH),
        .VAL_W    (VAL_W),
        .WINDOW   (WINDOW),
        .LFSR_SEED(16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mode        (mode),
        .load        (load),
        .intensity   (intensity),
        .spike_out   (spike_out),
        .window_start(window_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard bound on total simulated time
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checkCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rotl16(input int v, input int s);
        return ((v << s) | (v >> (16 - s))) & 32'h0000FFFF;
    endfunction

    function automatic int lfsrNext(input int v);
        return (v & 1) ? ((v >> 1) ^ 32'h0000B400) : (v >> 1);
    endfunction

    function automatic void modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            intM[c] = 0;
            accM[c] = 0;
        end
        wcntM = 0;
        lfsrM = 1;
        modeM = 0;
    endfunction

    function automatic void modelStep(input logic en, input logic [1:0] md, input logic ld,
                                      input logic [31:0] inten);
        int r;
        expSpike = '0;
        expWs    = 1'b0;
        if (ld) begin
            for (int c = 0; c < NUM_CH; c++) begin
                intM[c] = int'(inten[c*VAL_W +: VAL_W]);
                accM[c] = 0;
            end
            wcntM = 0;
            modeM = int'(md);
        end else if (int'(md) != modeM) begin
            for (int c = 0; c < NUM_CH; c++) accM[c] = 0;
            wcntM = 0;
            modeM = int'(md);
        end else if (en) begin
            case (md)
                2'b01: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        accM[c] = accM[c] + intM[c];
                        if (accM[c] >= LEVELS) begin
                            expSpike[c] = 1'b1;
                            accM[c]     = accM[c] - LEVELS;
                        end
                    end
                end
                2'b10: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        r           = rotl16(lfsrM, (3 * c) % 16) % LEVELS;
                        expSpike[c] = (r < intM[c]);
                    end
                    lfsrM = lfsrNext(lfsrM);
                end
                2'b11: begin
                    expWs = (wcntM == 0);
                    for (int c = 0; c < NUM_CH; c++)
                        expSpike[c] = (intM[c] != 0) && (wcntM == LEVELS - 1 - intM[c]);
                    wcntM = (wcntM + 1) % WINDOW;
                end
                default: ;
            endcase
        end
    endfunction

    // One clock: drive inputs, advance the model on the edge, compare just after it
    task automatic applyStimulus(input logic en, input logic [1:0] md, input logic ld,
                                 input logic [31:0] inten);
        enable    = en;
        mode      = md;
        load      = ld;
        intensity = inten;
        @(posedge clk);
        modelStep(en, md, ld, inten);
        #1;
        checkOutput("spike", 32'(spike_out), 32'(expSpike));
        checkOutput("wstart", 32'(window_start), 32'(expWs));
        load = 1'b0;
    endtask

    task automatic clearStats();
        for (int c = 0; c < NUM_CH; c++) begin
            cnt[c]       = 0;
            firstIdx[c]  = -1;
            secondIdx[c] = -1;
        end
        wsCount = 0;
        wsFirst = -1;
    endtask

    task automatic recordCycle(input int idx);
        for (int c = 0; c < NUM_CH; c++) begin
            if (spike_out[c]) begin
                cnt[c]++;
                if (firstIdx[c] < 0) firstIdx[c] = idx;
                else if (secondIdx[c] < 0) secondIdx[c] = idx;
            end
        end
        if (window_start) begin
            wsCount++;
            if (wsFirst < 0) wsFirst = idx;
        end
    endtask

    initial begin
        logic [31:0] vals;
        logic [3:0]  pat;
        logic [1:0]  curMode;
        int          offSpikes;

        rst_n     = 1'b0;
        enable    = 1'b0;
        mode      = 2'b00;
        load      = 1'b0;
        intensity = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetSpike", 32'(spike_out), 32'h0);
        checkOutput("resetWstart", 32'(window_start), 32'h0);
        rst_n = 1'b1;

        // RATE: load together with a mode change, then 256 enabled cycles
        vals = {8'd255, 8'd128, 8'd64, 8'd0};
        applyStimulus(1'b1, 2'b01, 1'b1, vals);
        clearStats();
        pat = '0;
        for (int c = 0; c < 257; c++) begin
            applyStimulus(1'b1, 2'b01, 1'b0, vals);
            if (c < 256) recordCycle(c);
            if (c < 4) pat[c] = spike_out[2];
        end
        checkOutput("rateCnt0", 32'(cnt[0]), 32'd0);
        checkOutput("rateCnt1", 32'(cnt[1]), 32'd64);
        checkOutput("rateCnt2", 32'(cnt[2]), 32'd128);
        checkOutput("rateCnt3", 32'(cnt[3]), 32'd255);
        checkOutput("ratePattern", 32'(pat), 32'hA);

        // Load plus mode change to TTFS while RATE would otherwise fire
        vals = {8'd0, 8'd1, 8'd200, 8'd255};
        applyStimulus(1'b1, 2'b11, 1'b1, vals);
        checkOutput("loadQuiet", 32'(spike_out), 32'h0);
        clearStats();
        for (int c = 0; c < 512; c++) begin
            applyStimulus(1'b1, 2'b11, 1'b0, vals);
            recordCycle(c);
        end
        checkOutput("ttfsWsFirst", 32'(wsFirst), 32'd0);
        checkOutput("ttfsWsCount", 32'(wsCount), 32'd2);
        checkOutput("ttfsCh0", 32'(firstIdx[0]), 32'd0);
        checkOutput("ttfsCh1", 32'(firstIdx[1]), 32'd55);
        checkOutput("ttfsCh2", 32'(firstIdx[2]), 32'd254);
        checkOutput("ttfsCh1Again", 32'(secondIdx[1]), 32'd311);
        checkOutput("ttfsCh3Count", 32'(cnt[3]), 32'd0);

        // TTFS with a 10-cycle enable gap after 30 cycles of the window
        applyStimulus(1'b1, 2'b11, 1'b1, vals);
        clearStats();
        offSpikes = 0;
        for (int c = 0; c < 300; c++) begin
            applyStimulus((c < 30 || c >= 40) ? 1'b1 : 1'b0, 2'b11, 1'b0, vals);
            recordCycle(c);
            if (c >= 30 && c < 40 && (spike_out != '0 || window_start)) offSpikes++;
        end
        checkOutput("gapQuiet", 32'(offSpikes), 32'd0);
        checkOutput("gapCh1", 32'(firstIdx[1]), 32'd65);
        checkOutput("gapCh2", 32'(firstIdx[2]), 32'd264);
        checkOutput("gapCh0Again", 32'(secondIdx[0]), 32'd266);

        // POISSON from the substituted seed of 1: first decision is fixed
        vals = {4{8'd128}};
        applyStimulus(1'b1, 2'b10, 1'b1, vals);
        clearStats();
        applyStimulus(1'b1, 2'b10, 1'b0, vals);
        checkOutput("poissonFirst", 32'(spike_out), 32'hF);
        recordCycle(0);
        for (int c = 1; c < 4096; c++) begin
            applyStimulus(1'b1, 2'b10, 1'b0, vals);
            recordCycle(c);
        end
        for (int c = 0; c < NUM_CH; c++)
            checkOutput($sformatf("poissonHalf%0d", c),
                        32'((cnt[c] >= 1898 && cnt[c] <= 2198) ? 1 : 0), 32'd1);

        vals = '0;
        applyStimulus(1'b1, 2'b10, 1'b1, vals);
        clearStats();
        for (int c = 0; c < 256; c++) begin
            applyStimulus(1'b1, 2'b10, 1'b0, vals);
            recordCycle(c);
        end
        checkOutput("poissonZero", 32'(cnt[0] + cnt[1] + cnt[2] + cnt[3]), 32'd0);

        vals = {4{8'd255}};
        applyStimulus(1'b1, 2'b10, 1'b1, vals);
        clearStats();
        for (int c = 0; c < 4096; c++) begin
            applyStimulus(1'b1, 2'b10, 1'b0, vals);
            recordCycle(c);
        end
        for (int c = 0; c < NUM_CH; c++)
            checkOutput($sformatf("poissonFull%0d", c), 32'((cnt[c] >= 4000) ? 1 : 0), 32'd1);

        // Randomized traffic: occasional loads, mode switches and enable drops
        curMode = 2'b01;
        vals    = $urandom;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 3) curMode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 5) begin
                vals = $urandom;
                applyStimulus($urandom_range(0, 99) < 85, curMode, 1'b1, vals);
            end else begin
                applyStimulus($urandom_range(0, 99) < 85, curMode, 1'b0, vals);
            end
        end

        // Asynchronous reset while every channel is spiking in RATE
        vals = {4{8'd255}};
        applyStimulus(1'b1, 2'b01, 1'b1, vals);
        repeat (3) applyStimulus(1'b1, 2'b01, 1'b0, vals);
        checkOutput("preResetBusy", 32'(spike_out), 32'hF);
        rst_n = 1'b0;
        #2;
        checkOutput("asyncSpike", 32'(spike_out), 32'h0);
        checkOutput("asyncWstart", 32'(window_start), 32'h0);
        modelReset();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 99) < 5) curMode = 2'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 99) < 90, curMode, ($urandom_range(0, 99) < 3), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
